rx_capture_decimator: RTL
=========================

// Module: rx_capture_decimator
// PURPOSE
//  rx_clk_i-domain stage directly upstream of the 12-bit CDC sample FIFO.
//  Takes raw signed ADC samples, waits for an armed level trigger, then boxcar-decimates by 2**LOG2_R.
//  Produces exactly capture_len output samples as single-cycle wr_en_o/wr_data_o strobes into the FIFO write port.
// PARAMETERS
//  LOG2_R  2   decimation ratio R = 2**LOG2_R; legal 0..6 (LOG2_R=0: pass-through after trigger)
//  LEN_W   16  width of capture length and output-sample counter
// PORTS
//  rx_clk_i       in   1      sample clock; all logic on its rising edge
//  rst_n_i        in   1      asynchronous, active-low reset
//  adc_valid_i    in   1      adc_data_i carries a sample this cycle
//  adc_data_i     in   12     signed two's-complement ADC sample
//  arm_i          in   1      single-cycle arm request
//  trig_level_i   in   12     signed trigger threshold; sampled when arm is accepted
//  capture_len_i  in   LEN_W  output samples per capture; sampled when arm is accepted
//  dc_offset_i    in   12     signed offset; exists only with RXCAP_DC_OFFSET_EN
//  wr_en_o        out  1      one-cycle strobe: wr_data_o valid (drives FIFO wr_en_i)
//  wr_data_o      out  12     signed decimated sample (drives FIFO wr_data_i)
//  busy_o         out  1      high in ARMED and CAPTURE
//  done_o         out  1      one-cycle pulse when the last sample of a capture is written
// BEHAVIOUR
//  Reset values: wr_en_o=0, wr_data_o=0, busy_o=0, done_o=0, FSM=IDLE; accumulator, counters and prev-sample cleared.
//  Reset asserted mid-capture aborts at once; no partial sample is emitted and no done_o pulse occurs.
//  s = working sample = adc_data_i, or the offset-corrected value (see CONFIGURATION); only cycles with adc_valid_i=1 count.
//  FSM states:
//   IDLE: arm_i=1 and capture_len_i!=0 -> latch trig_level_i and capture_len_i, clear prev_valid, go to ARMED.
//         arm_i with capture_len_i=0 is ignored.
//   ARMED: first valid s only loads prev and sets prev_valid; no trigger is possible on it.
//          A later valid s triggers on a rising crossing: prev < level && s >= level (signed compare); then go to CAPTURE.
//          Otherwise prev <= s. arm_i is ignored.
//   CAPTURE: the triggering s is the first accumulated sample.
//          Accumulator is signed, 12+LOG2_R bits; no overflow is possible.
//          After the R-th valid s: wr_data_o <= (acc + s) >>> LOG2_R (arithmetic shift, floor), wr_en_o=1 for one cycle.
//          Output latency: the cycle after the R-th sample is accepted. The accumulator then restarts with the next valid s.
//          On the capture_len-th output: done_o=1 in the same cycle as that wr_en_o, and the FSM returns to IDLE.
//          arm_i is ignored in CAPTURE.
//  Back-to-back: arm_i is accepted in the cycle after done_o.
//  adc_valid_i gaps stall accumulation and do not reset it.
//  wr_en_o never exceeds one pulse per R valid samples. No backpressure: the FIFO must keep up.
//  busy_o is registered: 1 from the cycle after arm acceptance through the done_o cycle inclusive.
// CONFIGURATION
//  RXCAP_DC_OFFSET_EN defined:
//   - dc_offset_i is present.
//   - s = saturate12(adc_data_i - dc_offset_i), computed in 13 bits and clamped to [-2048, 2047].
//   - Applies to both trigger compare and accumulation; dc_offset_i is used live, not latched.
//   - Adds one register stage on s, so all latencies grow by 1 cycle.
//  RXCAP_DC_OFFSET_EN undefined: no dc_offset_i port; s = adc_data_i with no extra stage.
// TESTING
//  1 Reset: rst_n_i=0 mid-CAPTURE (LOG2_R=2, 2 of 4 samples in) -> outputs 0 immediately; after release, IDLE with no wr_en_o.
//  2 Trigger: level=100, len=3, valid ramp 0,50,99,100,101..., LOG2_R=2
//    -> CAPTURE starts at sample 100; outputs 101 (floor(406/4)), 105, 109.
//    -> 3 wr_en_o pulses; done_o with the 3rd pulse; busy_o falls the next cycle.
//  3 No false trigger: level=0; first ARMED sample=5, then constant 5 -> stays ARMED, no wr_en_o.
//    Next sample -1 then 0 -> triggers on the 0.
//  4 Negative floor: LOG2_R=2, post-trigger samples -1,-1,-1,-2 -> wr_data_o=-2 (12'hFFE).
//  5 Gaps: adc_valid_i toggling 1/0 -> exactly one wr_en_o per 4 valid samples, data unaffected.
//    arm_i pulses during CAPTURE -> ignored.
//  6 RXCAP_DC_OFFSET_EN: offset=-100, adc=2000 -> s saturates to 2047; offset=0 matches test 2 with latency +1.
//    Also capture_len=0 with arm_i -> stays IDLE.

Source files
------------

// File: rtl/rx_capture_decimator.sv
// rx_capture_decimator: sample-clock stage in front of the 12-bit CDC sample FIFO.
// Waits for an armed rising-level trigger, then boxcar-decimates by 2**LOG2_R and
// writes exactly capture_len decimated samples into the FIFO write port.
//
// Optional feature macro: RXCAP_DC_OFFSET_EN
//   defined   -> dc_offset_i port exists; the working sample is
//                saturate12(adc_data_i - dc_offset_i), registered once, so every
//                latency grows by one cycle.
//   undefined -> the working sample is adc_data_i with no extra stage.
//
// Output handshake: wr_en_o is a one-cycle valid strobe with no ready; the FIFO
// must accept every strobe. At most one strobe is produced per 2**LOG2_R valid samples.
//
// The FSM state is visible as the internal signal fsm_state (IDLE/ARMED/CAPTURE).
module rx_capture_decimator #(
  parameter int LOG2_R = 2,
  parameter int LEN_W  = 16
) (
  input  logic             rx_clk_i,
  input  logic             rst_n_i,
  input  logic             adc_valid_i,
  input  logic [11:0]      adc_data_i,
  input  logic             arm_i,
  input  logic [11:0]      trig_level_i,
  input  logic [LEN_W-1:0] capture_len_i,
`ifdef RXCAP_DC_OFFSET_EN
  input  logic [11:0]      dc_offset_i,
`endif
  output logic             wr_en_o,
  output logic [11:0]      wr_data_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam int ACC_W = 12 + LOG2_R;
  localparam int R     = 1 << LOG2_R;
  localparam int CNT_W = (LOG2_R > 0) ? LOG2_R : 1;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ARMED   = 2'd1;
  localparam logic [1:0] ST_CAPTURE = 2'd2;

  logic [1:0]              fsm_state;
  logic signed [11:0]      s;
  logic                    s_valid;
  logic signed [11:0]      level_q;
  logic [LEN_W-1:0]        len_q;
  logic signed [11:0]      prev_q;
  logic                    prev_valid_q;
  logic signed [ACC_W-1:0] acc_q;
  logic [CNT_W-1:0]        samp_cnt_q;
  logic [LEN_W-1:0]        out_cnt_q;

`ifdef RXCAP_DC_OFFSET_EN
  logic signed [12:0] diff;
  logic signed [11:0] sat;
  logic signed [11:0] s_q;
  logic               s_valid_q;

  // Offset-correct in 13 bits and clamp back into the signed 12-bit range.
  always_comb begin
    diff = $signed({adc_data_i[11], adc_data_i}) - $signed({dc_offset_i[11], dc_offset_i});
    if (diff > 13'sd2047) begin
      sat = 12'sd2047;
    end else if (diff < -13'sd2048) begin
      sat = -12'sd2048;
    end else begin
      sat = diff[11:0];
    end
  end

  // Register the corrected sample; this is the extra pipeline stage.
  always_ff @(posedge rx_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      s_q       <= '0;
      s_valid_q <= 1'b0;
    end else begin
      s_q       <= sat;
      s_valid_q <= adc_valid_i;
    end
  end

  assign s       = s_q;
  assign s_valid = s_valid_q;
`else
  assign s       = $signed(adc_data_i);
  assign s_valid = adc_valid_i;
`endif

  logic signed [ACC_W-1:0] s_ext;
  logic signed [ACC_W-1:0] sum;
  logic signed [11:0]      dec_val;
  logic                    trig_hit;
  logic                    take;
  logic                    last_in_block;
  logic                    last_out;

  // Trigger detection, accumulation and end-of-block / end-of-capture decisions.
  always_comb begin
    s_ext         = ACC_W'(s);
    sum           = acc_q + s_ext;
    dec_val       = 12'(sum >>> LOG2_R);
    trig_hit      = prev_valid_q && (prev_q < level_q) && (s >= level_q);
    take          = s_valid && ((fsm_state == ST_CAPTURE) ||
                                ((fsm_state == ST_ARMED) && trig_hit));
    last_in_block = (samp_cnt_q == CNT_W'(R - 1));
    last_out      = ((out_cnt_q + LEN_W'(1)) == len_q);
  end

  // Capture FSM with accumulator, counters and registered outputs.
  always_ff @(posedge rx_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      fsm_state    <= ST_IDLE;
      level_q      <= '0;
      len_q        <= '0;
      prev_q       <= '0;
      prev_valid_q <= 1'b0;
      acc_q        <= '0;
      samp_cnt_q   <= '0;
      out_cnt_q    <= '0;
      wr_en_o      <= 1'b0;
      wr_data_o    <= '0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
    end else begin
      wr_en_o <= 1'b0;
      done_o  <= 1'b0;
      case (fsm_state)
        ST_IDLE: begin
          busy_o <= 1'b0;
          if (arm_i && (capture_len_i != '0)) begin
            level_q      <= $signed(trig_level_i);
            len_q        <= capture_len_i;
            prev_valid_q <= 1'b0;
            acc_q        <= '0;
            samp_cnt_q   <= '0;
            out_cnt_q    <= '0;
            busy_o       <= 1'b1;
            fsm_state    <= ST_ARMED;
          end
        end
        ST_ARMED: begin
          if (s_valid) begin
            if (trig_hit) begin
              fsm_state <= ST_CAPTURE;
            end else begin
              prev_q       <= s;
              prev_valid_q <= 1'b1;
            end
          end
        end
        ST_CAPTURE: begin
        end
        default: fsm_state <= ST_IDLE;
      endcase

      // The triggering sample is the first one accumulated; later state
      // assignment here overrides the ARMED->CAPTURE move for R=1, len=1.
      if (take) begin
        if (last_in_block) begin
          wr_en_o    <= 1'b1;
          wr_data_o  <= dec_val;
          acc_q      <= '0;
          samp_cnt_q <= '0;
          out_cnt_q  <= out_cnt_q + LEN_W'(1);
          if (last_out) begin
            done_o    <= 1'b1;
            fsm_state <= ST_IDLE;
          end
        end else begin
          acc_q      <= sum;
          samp_cnt_q <= samp_cnt_q + CNT_W'(1);
        end
      end
    end
  end

endmodule
